// File: rtl/aes_scan_responder.sv
// Device-side AES scan-chain responder: serial frame load, core launch, ciphertext capture.
// Optional watchdog on the core run enabled by defining AES_SCAN_TIMEOUT_EN.
module aes_scan_responder #(
  parameter int unsigned FRAME_W = 387,
  parameter int unsigned CT_W    = 128,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_en,
  input  logic               scan_in,
  output logic               scan_out,
  input  logic               load_i,
  output logic [FRAME_W-1:0] sc_out,
  output logic [127:0]       pt_o,
  output logic [255:0]       key_o,
  output logic               pt_sel_o,
  output logic               key_sel_o,
  output logic               ct_out_sel_o,
  output logic               core_start,
  input  logic               core_done,
  input  logic [CT_W-1:0]    core_ct,
  output logic               trigger,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [127:0]       pt_q, pt_d;
  logic [255:0]       key_q, key_d;
  logic               pt_sel_q, pt_sel_d;
  logic               key_sel_q, key_sel_d;
  logic               ct_sel_q, ct_sel_d;
  logic               load_q, load_d;
  logic               start_q, start_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic               load_rise;

`ifdef AES_SCAN_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  assign load_rise = load_i & ~load_q;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    pt_d      = pt_q;
    key_d     = key_q;
    pt_sel_d  = pt_sel_q;
    key_sel_d = key_sel_q;
    ct_sel_d  = ct_sel_q;
    load_d    = load_i;
    start_d   = 1'b0;
    trig_d    = 1'b0;
    busy_d    = busy_q;
`ifdef AES_SCAN_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A load edge takes priority over a concurrent shift.
        if (load_rise) begin
          pt_d      = sr_q[FRAME_W-1 -: 128];
          key_d     = sr_q[FRAME_W-129 -: 256];
          pt_sel_d  = sr_q[2];
          key_sel_d = sr_q[1];
          ct_sel_d  = sr_q[0];
          start_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = StRun;
`ifdef AES_SCAN_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else if (scan_en) begin
          sr_d = {sr_q[FRAME_W-2:0], scan_in};
        end
      end
      StRun: begin
        if (core_done) begin
          if (ct_sel_q) sr_d[CT_W-1:0] = core_ct;
          trig_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
`ifdef AES_SCAN_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      pt_q      <= '0;
      key_q     <= '0;
      pt_sel_q  <= 1'b0;
      key_sel_q <= 1'b0;
      ct_sel_q  <= 1'b0;
      load_q    <= 1'b0;
      start_q   <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AES_SCAN_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      pt_q      <= pt_d;
      key_q     <= key_d;
      pt_sel_q  <= pt_sel_d;
      key_sel_q <= key_sel_d;
      ct_sel_q  <= ct_sel_d;
      load_q    <= load_d;
      start_q   <= start_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
`ifdef AES_SCAN_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign scan_out     = sr_q[FRAME_W-1];
  assign sc_out       = sr_q;
  assign pt_o         = pt_q;
  assign key_o        = key_q;
  assign pt_sel_o     = pt_sel_q;
  assign key_sel_o    = key_sel_q;
  assign ct_out_sel_o = ct_sel_q;
  assign core_start   = start_q;
  assign trigger      = trig_q;
  assign busy_o       = busy_q;
`ifdef AES_SCAN_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule
